// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches over a req/gnt/rvalid
// port, buffers {pc, instr} pairs in a small FIFO and flushes on redirect.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     mem_req_o,
  output logic [31:0]              mem_addr_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [31:0]              mem_rdata_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  output logic                     instr_valid_o,
  output logic [31:0]              instr_o,
  output logic [31:0]              instr_pc_o,
  input  logic                     instr_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  entry_t             head_q, head_d;
  entry_t             mem_q [DEPTH];
  entry_t             push_entry;
  logic               push, pop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default infers a latch.
    push       = (state_q == WAIT) && mem_rvalid_i && !redirect_i;
    pop        = (count_q != '0) && instr_ready_i && !redirect_i;
    push_entry = '{pc: fetch_pc_q - 32'd4, instr: mem_rdata_i};
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    head_d     = head_q;

    if (redirect_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // The head register holds its value while empty; when the new head slot is
    // the one being written this cycle, forward the incoming word.
    if (count_d != '0) begin
      head_d = (push && (wr_ptr_q == rd_ptr_d)) ? push_entry : mem_q[rd_ptr_d];
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;

    unique case (state_q)
      IDLE:    if (count_q < DEPTH_C) state_d = REQ;
      REQ:     if (mem_gnt_i) begin
                 fetch_pc_d = fetch_pc_q + 32'd4;
                 state_d    = WAIT;
               end
      WAIT:    if (mem_rvalid_i) state_d = (count_d < DEPTH_C) ? REQ : IDLE;
      DISCARD: if (mem_rvalid_i) state_d = REQ;
      default: state_d = IDLE;
    endcase

    // A redirect overrides everything; an in-flight request still owes us a
    // response, which DISCARD swallows before the new path is fetched.
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      unique case (state_q)
        IDLE:    state_d = REQ;
        REQ:     state_d = mem_gnt_i    ? DISCARD : REQ;
        WAIT:    state_d = mem_rvalid_i ? REQ     : DISCARD;
        DISCARD: state_d = mem_rvalid_i ? REQ     : DISCARD;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read
  // after it has been written, and leaving it out of reset keeps it a plain RAM.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign mem_req_o     = (state_q == REQ);
  assign mem_addr_o    = fetch_pc_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = head_q.instr;
  assign instr_pc_o    = head_q.pc;
  assign count_o       = count_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: a reactive memory model, directed
// scenarios, and a scoreboard monitor that checks every consumed instruction.
module tb_instr_prefetch_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;
  logic [2:0]  count_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  // Memory-model controls, written only by the stimulus process.
  logic gnt_en   = 1'b1;
  logic hold_rv  = 1'b0;
  logic stray_rv = 1'b0;
  // Memory-model state, written only by the model.
  logic        pending    = 1'b0;
  logic        stray_done = 1'b0;
  logic        stray_now;
  logic [31:0] pend_addr  = '0;
  logic [31:0] gnt_addr   = '0;

  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] dat(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    sb.push_back('{pc: pc, instr: dat(pc)});
  endtask

  // Memory responder: grants in the request cycle, returns data one cycle later.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      pending      = 1'b0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
    end else begin
      if (mem_rvalid_i) pending = 1'b0;
      if (mem_gnt_i) begin
        pending   = 1'b1;
        pend_addr = gnt_addr;
      end
      stray_now = stray_rv && !stray_done;
      if (stray_now) stray_done = 1'b1;
      mem_rvalid_i = (pending && !hold_rv) || stray_now;
      mem_rdata_i  = stray_now ? 32'hBAD0_BAD0 : (pending ? dat(pend_addr) : 32'h0);
      mem_gnt_i    = mem_req_o && gnt_en && !pending;
      gnt_addr     = mem_addr_o;
    end
  end

  // Scoreboard monitor: a pop happens at the next edge unless a redirect flushes.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i && instr_valid_o && instr_ready_i && !redirect_i) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc %h, expected no instruction", instr_pc_o);
      end else begin
        e = sb.pop_front();
        check("head_pc", instr_pc_o, e.pc);
        check("head_instr", instr_o, e.instr);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset();
    rst_i         = 1'b0;
    instr_ready_i = 1'b0;
    redirect_i    = 1'b0;
    hold_rv       = 1'b0;
    step();
    step();
    sb.delete();
    rst_i = 1'b1;
  endtask

  task automatic drain(input bit max1);
    instr_ready_i = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (max1) check("count_le_1", 32'(count_o <= 3'd1), 32'd1);
      if (sb.size() == 0) break;
    end
    instr_ready_i = 1'b0;
    check("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_state(input string name, input logic [2:0] cnt);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (count_o == cnt && !mem_req_o) begin
        found = 1'b1;
        break;
      end
    end
    check(name, 32'(found), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    step();
    step();
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc", instr_pc_o, 32'h0);

    // A: sequential fetch with decode always ready
    rst_i = 1'b1;
    step();
    check("a_first_req", 32'(mem_req_o), 32'd1);
    check("a_first_addr", mem_addr_o, 32'h0);
    expect_pc(32'h0);
    expect_pc(32'h4);
    expect_pc(32'h8);
    drain(1'b1);

    // B: fill to DEPTH, then a single pop restarts fetch at 0x10
    do_reset();
    for (int i = 0; i < 20; i++) step();
    check("b_full_count", 32'(count_o), 32'd4);
    check("b_full_req", 32'(mem_req_o), 32'd0);
    check("b_full_valid", 32'(instr_valid_o), 32'd1);
    step();
    check("b_idle_count", 32'(count_o), 32'd4);
    check("b_idle_req", 32'(mem_req_o), 32'd0);
    expect_pc(32'h0);
    instr_ready_i = 1'b1;
    step();
    instr_ready_i = 1'b0;
    check("b_pop_count", 32'(count_o), 32'd3);
    step();
    check("b_refetch_req", 32'(mem_req_o), 32'd1);
    check("b_refetch_addr", mem_addr_o, 32'h10);
    expect_pc(32'h4);
    expect_pc(32'h8);
    expect_pc(32'hC);
    expect_pc(32'h10);
    drain(1'b0);

    // C: redirect in WAIT with two entries buffered
    do_reset();
    wait_state("c_reach_wait", 3'd2);
    hold_rv       = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    step();
    redirect_i = 1'b0;
    check("c_flush_count", 32'(count_o), 32'd0);
    check("c_flush_valid", 32'(instr_valid_o), 32'd0);
    check("c_discard_req", 32'(mem_req_o), 32'd0);
    check("c_target_addr", mem_addr_o, 32'h100);
    hold_rv = 1'b0;
    step();
    check("c_dropped_count", 32'(count_o), 32'd0);
    check("c_new_req", 32'(mem_req_o), 32'd1);
    check("c_new_addr", mem_addr_o, 32'h100);
    expect_pc(32'h100);
    expect_pc(32'h104);
    drain(1'b0);

    // D: redirect together with rvalid and a pop
    do_reset();
    wait_state("d_reach_wait", 3'd1);
    instr_ready_i = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0300;
    step();
    redirect_i = 1'b0;
    check("d_flush_count", 32'(count_o), 32'd0);
    check("d_flush_valid", 32'(instr_valid_o), 32'd0);
    check("d_req", 32'(mem_req_o), 32'd1);
    check("d_addr", mem_addr_o, 32'h300);
    expect_pc(32'h300);
    expect_pc(32'h304);
    drain(1'b0);

    // E: grant withheld, redirect while requesting
    gnt_en = 1'b0;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step();
      redirect_i = 1'b0;
      check("e_req_held", 32'(mem_req_o), 32'd1);
      check("e_addr", mem_addr_o, (k <= 3) ? 32'h0 : 32'h200);
      check("e_count", 32'(count_o), 32'd0);
      if (k == 3) begin
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
      end
    end
    gnt_en = 1'b1;
    expect_pc(32'h200);
    expect_pc(32'h204);
    expect_pc(32'h208);
    drain(1'b0);

    // F: asynchronous reset mid-WAIT, stray rvalid after release
    do_reset();
    wait_state("f_reach_wait", 3'd3);
    #1;
    rst_i = 1'b0;
    #1;
    check("f_rst_req", 32'(mem_req_o), 32'd0);
    check("f_rst_addr", mem_addr_o, 32'h0);
    check("f_rst_count", 32'(count_o), 32'd0);
    check("f_rst_valid", 32'(instr_valid_o), 32'd0);
    check("f_rst_instr", instr_o, 32'h0);
    check("f_rst_pc", instr_pc_o, 32'h0);
    step();
    step();
    sb.delete();
    stray_rv = 1'b1;
    rst_i    = 1'b1;
    step();
    check("f_stray_count", 32'(count_o), 32'd0);
    check("f_restart_req", 32'(mem_req_o), 32'd1);
    check("f_restart_addr", mem_addr_o, 32'h0);
    expect_pc(32'h0);
    expect_pc(32'h4);
    drain(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
